// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, IR, IDCODE, BYPASS and a bank of
// NUM_DR user data registers, each with a shift stage, a shadow stage and an update strobe.
module jtag_tap_multi #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter int unsigned         DR_WIDTH     = 8,
  parameter int unsigned         NUM_DR       = 2,
  parameter logic [IR_WIDTH-1:0] USER_BASE    = 4'd4,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'd1,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                       TCK,
  input  logic                       RST,
  input  logic                       TMS,
  input  logic                       TDI,
  output logic                       TDO,
  output logic                       TDO_EN,
  output logic [IR_WIDTH-1:0]        IR,
  input  logic [NUM_DR*DR_WIDTH-1:0] DR_IN,
  output logic [NUM_DR*DR_WIDTH-1:0] DR_OUT,
  output logic [NUM_DR-1:0]          DR_UPDATE
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  if (IR_WIDTH < 2) begin : g_chk_ir_width
    $error("jtag_tap_multi: IR_WIDTH must be at least 2");
  end
  if (DR_WIDTH < 1) begin : g_chk_dr_width
    $error("jtag_tap_multi: DR_WIDTH must be at least 1");
  end
  if (NUM_DR < 1 || NUM_DR > (2**IR_WIDTH) - 3) begin : g_chk_num_dr
    $error("jtag_tap_multi: NUM_DR out of range");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_chk_idcode
    $error("jtag_tap_multi: IDCODE_VALUE bit 0 must be 1");
  end

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_shift;
  logic                bypass_shift;
  logic                sel_idcode;
  logic [NUM_DR-1:0]   sel_user;
  logic [NUM_DR-1:0]   user_lsb;
  logic                dr_tdo;

  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    unique case (s)
      TLR:      return tms ? TLR      : RTI;
      RTI:      return tms ? SEL_DR   : RTI;
      SEL_DR:   return tms ? SEL_IR   : CAP_DR;
      CAP_DR:   return tms ? EX1_DR   : SHIFT_DR;
      SHIFT_DR: return tms ? EX1_DR   : SHIFT_DR;
      EX1_DR:   return tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   return tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR   : RTI;
      SEL_IR:   return tms ? TLR      : CAP_IR;
      CAP_IR:   return tms ? EX1_IR   : SHIFT_IR;
      SHIFT_IR: return tms ? EX1_IR   : SHIFT_IR;
      EX1_IR:   return tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   return tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return tms ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  // Written as shift-then-overwrite-MSB so a 1-bit register needs no special case.
  function automatic logic [DR_WIDTH-1:0] shift_user(input logic [DR_WIDTH-1:0] v, input logic b);
    logic [DR_WIDTH-1:0] r;
    r = v >> 1;
    r[DR_WIDTH-1] = b;
    return r;
  endfunction

  assign sel_idcode = (IR == IDCODE_INSTR);

  always_ff @(posedge TCK) begin
    if (RST) begin
      state        <= TLR;
      IR           <= IDCODE_INSTR;
      ir_shift     <= '0;
      idcode_shift <= '0;
      bypass_shift <= 1'b0;
    end else begin
      state <= next_state(state, TMS);
      case (state)
        TLR:      IR <= IDCODE_INSTR;
        CAP_IR:   ir_shift <= IR_CAPTURE;
        SHIFT_IR: ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        UPD_IR:   IR <= ir_shift;
        CAP_DR: begin
          if (sel_idcode)     idcode_shift <= IDCODE_VALUE;
          else if (~|sel_user) bypass_shift <= 1'b0;
        end
        SHIFT_DR: begin
          if (sel_idcode)     idcode_shift <= {TDI, idcode_shift[31:1]};
          else if (~|sel_user) bypass_shift <= TDI;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_DR; k++) begin : g_user
    localparam logic [IR_WIDTH-1:0] CODE = USER_BASE + IR_WIDTH'(k);

    if (CODE == IDCODE_INSTR || CODE == {IR_WIDTH{1'b1}}) begin : g_chk_alias
      $error("jtag_tap_multi: user DR code aliases IDCODE or BYPASS");
    end

    logic [DR_WIDTH-1:0] shift_q;
    logic [DR_WIDTH-1:0] shadow_q;
    logic                upd_q;

    assign sel_user[k]                     = (IR == CODE);
    assign user_lsb[k]                     = shift_q[0];
    assign DR_OUT[k*DR_WIDTH +: DR_WIDTH]  = shadow_q;
    assign DR_UPDATE[k]                    = upd_q;

    always_ff @(posedge TCK) begin
      if (RST) begin
        shift_q  <= '0;
        shadow_q <= '0;
        upd_q    <= 1'b0;
      end else begin
        upd_q <= 1'b0;
        if (sel_user[k]) begin
          case (state)
            CAP_DR:   shift_q <= DR_IN[k*DR_WIDTH +: DR_WIDTH];
            SHIFT_DR: shift_q <= shift_user(shift_q, TDI);
            UPD_DR: begin
              shadow_q <= shift_q;
              upd_q    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    dr_tdo = bypass_shift;
    if (sel_idcode)     dr_tdo = idcode_shift[0];
    else if (|sel_user) dr_tdo = |(sel_user & user_lsb);
    TDO = 1'b0;
    if (state == SHIFT_IR)      TDO = ir_shift[0];
    else if (state == SHIFT_DR) TDO = dr_tdo;
  end

  assign TDO_EN = (state == SHIFT_IR) || (state == SHIFT_DR);

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Directed bench for jtag_tap_multi: a table walk through the TAP with a BYPASS scan,
// then hand-written scans for IDCODE, user registers, pause insertion and reset cases.
module tb_jtag_tap_multi;

  logic        tck = 1'b0;
  logic        rst = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  ir;
  logic [15:0] dr_in = 16'h0000;
  logic [15:0] dr_out;
  logic [1:0]  dr_update;

  int errors = 0;
  int checks = 0;

  jtag_tap_multi #(
    .IR_WIDTH(4),
    .DR_WIDTH(8),
    .NUM_DR(2),
    .USER_BASE(4'd4),
    .IDCODE_INSTR(4'd1),
    .IDCODE_VALUE(32'h1000_0001)
  ) dut (
    .TCK(tck),
    .RST(rst),
    .TMS(tms),
    .TDI(tdi),
    .TDO(tdo),
    .TDO_EN(tdo_en),
    .IR(ir),
    .DR_IN(dr_in),
    .DR_OUT(dr_out),
    .DR_UPDATE(dr_update)
  );

  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        tms;
    logic        tdi;
    logic        exp_tdo;
    logic        exp_en;
    logic [3:0]  exp_ir;
    logic [1:0]  exp_upd;
    logic [15:0] exp_dr;
  } vec_t;

  vec_t vt [26];

  function automatic vec_t mk(input logic r, input logic t, input logic d,
                              input logic o, input logic e, input logic [3:0] i);
    vec_t v;
    v.rst = r; v.tms = t; v.tdi = d;
    v.exp_tdo = o; v.exp_en = e; v.exp_ir = i;
    v.exp_upd = 2'b00; v.exp_dr = 16'h0000;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle away from the edge before sampling.
  task automatic clk(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] code);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clk(i == 3, code[i]);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  // From RTI: capture, shift n bits LSB first, finish in UPD_DR.
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      clk(i == n - 1, din[i]);
    end
    clk(1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  din;

    //            rst   tms   tdi   tdo   en    ir
    vt[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);  // reset -> TLR
    vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);  // RTI
    vt[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);  // SEL_DR
    vt[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);  // SEL_IR
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);  // CAP_IR
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1);  // SHIFT_IR, stage 0001
    vt[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1);  // stage 1000
    vt[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1);  // stage 1100
    vt[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1);  // stage 1110
    vt[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);  // EX1_IR, stage 1111
    vt[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);  // UPD_IR
    vt[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);  // RTI, IR updated
    vt[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);  // SEL_DR
    vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);  // CAP_DR
    vt[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);  // SHIFT_DR, bypass captured 0
    vt[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    vt[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    vt[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    vt[18] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    vt[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);  // EX1_DR
    vt[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);  // UPD_DR
    vt[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);  // RTI, bypass update has no effect
    vt[22] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);  // SEL_DR
    vt[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);  // SEL_IR
    vt[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);  // TLR entered
    vt[25] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);  // TLR forces IDCODE

    for (int i = 0; i < 26; i++) begin
      rst = vt[i].rst;
      clk(vt[i].tms, vt[i].tdi);
      check($sformatf("row%0d tdo", i), tdo, vt[i].exp_tdo);
      check($sformatf("row%0d tdo_en", i), tdo_en, vt[i].exp_en);
      check($sformatf("row%0d ir", i), ir, vt[i].exp_ir);
      check($sformatf("row%0d dr_update", i), dr_update, vt[i].exp_upd);
      check($sformatf("row%0d dr_out", i), dr_out, vt[i].exp_dr);
    end

    // IDCODE scan straight after reset
    rst = 1'b1;
    clk(1'b0, 1'b0);
    rst = 1'b0;
    clk(1'b0, 1'b0);
    scan_dr(32'h0, 32, d);
    check("idcode stream", d, 32'h1000_0001);
    check("idcode ir", ir, 4'h1);
    clk(1'b0, 1'b0);
    check("idcode no update", dr_update, 2'b00);
    check("idcode dr_out", dr_out, 16'h0000);

    // User DR 0: capture 0x3C, load 0xA5
    dr_in = 16'h963C;
    load_ir(4'h4);
    check("dr0 ir", ir, 4'h4);
    scan_dr({24'h0, 8'hA5}, 8, d);
    check("dr0 capture stream", d, 32'h0000_003C);
    clk(1'b0, 1'b0);
    check("dr0 dr_out", dr_out, 16'h00A5);
    check("dr0 strobe", dr_update, 2'b01);
    clk(1'b0, 1'b0);
    check("dr0 strobe one cycle", dr_update, 2'b00);
    check("dr0 dr_out hold", dr_out, 16'h00A5);

    // User DR 1 with PAUSE_DR / EX2_DR inserted after three bits
    dr_in = 16'hC33C;
    load_ir(4'h5);
    check("dr1 ir", ir, 4'h5);
    check("dr1 selection keeps dr_out", dr_out, 16'h00A5);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    din = 8'h5A;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      d[i] = tdo;
      clk(i == 2, din[i]);
    end
    check("dr1 ex1 tdo_en", tdo_en, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b1);
    check("dr1 pause tdo", tdo, 1'b0);
    check("dr1 pause tdo_en", tdo_en, 1'b0);
    clk(1'b1, 1'b0);
    check("dr1 ex2 no update", dr_update, 2'b00);
    clk(1'b0, 1'b0);
    check("dr1 resume tdo_en", tdo_en, 1'b1);
    for (int i = 3; i < 8; i++) begin
      d[i] = tdo;
      clk(i == 7, din[i]);
    end
    clk(1'b1, 1'b0);
    check("dr1 pre-update dr_out", dr_out, 16'h00A5);
    clk(1'b0, 1'b0);
    check("dr1 capture stream", d, 32'h0000_00C3);
    check("dr1 dr_out", dr_out, 16'h5AA5);
    check("dr1 strobe", dr_update, 2'b10);
    clk(1'b0, 1'b0);
    check("dr1 strobe one cycle", dr_update, 2'b00);

    // TMS=1 x5 from mid-scan of BYPASS reaches TLR without touching user state
    load_ir(4'hF);
    check("tlr5 ir before", ir, 4'hF);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b1);
    clk(1'b0, 1'b0);
    check("tlr5 mid-scan tdo_en", tdo_en, 1'b1);
    for (int i = 0; i < 5; i++) begin
      clk(1'b1, 1'b0);
      check($sformatf("tlr5 step%0d no update", i), dr_update, 2'b00);
    end
    check("tlr5 tdo_en", tdo_en, 1'b0);
    clk(1'b1, 1'b0);
    check("tlr5 ir", ir, 4'h1);
    check("tlr5 dr_out", dr_out, 16'h5AA5);

    // Reset during SHIFT_IR with IR=5
    clk(1'b0, 1'b0);
    load_ir(4'h5);
    check("rst ir before", ir, 4'h5);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    check("rst shift_ir tdo_en", tdo_en, 1'b1);
    check("rst shift_ir capture", tdo, 1'b1);
    clk(1'b0, 1'b1);
    clk(1'b0, 1'b0);
    rst = 1'b1;
    clk(1'b0, 1'b1);
    rst = 1'b0;
    check("rst ir", ir, 4'h1);
    check("rst dr_out", dr_out, 16'h0000);
    check("rst tdo", tdo, 1'b0);
    check("rst tdo_en", tdo_en, 1'b0);
    check("rst dr_update", dr_update, 2'b00);
    clk(1'b0, 1'b0);
    check("rst rti ir", ir, 4'h1);
    check("rst rti tdo_en", tdo_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
